// File: rtl/conv_window_buffer_if.sv
// Pixel stream in, 3x3 window out, and the calc handshake between the
// window buffer and the convolution stages. The master side is the
// pixel source and the convolution stage. The slave side is the window buffer.
interface conv_window_buffer_if #(
    parameter int CNT_W = 8
) ();
    logic [3:0]           pixel_in;
    logic                 pixel_valid;
    logic                 pixel_ready;
    logic                 calc_done;
    logic [2:0][2:0][3:0] pixels;
    logic                 calc_enable;
    logic [CNT_W-1:0]     win_row;
    logic [CNT_W-1:0]     win_col;
    logic                 frame_done;

    modport master (
        output pixel_in,
        output pixel_valid,
        output calc_done,
        input  pixel_ready,
        input  pixels,
        input  calc_enable,
        input  win_row,
        input  win_col,
        input  frame_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        input  calc_done,
        output pixel_ready,
        output pixels,
        output calc_enable,
        output win_row,
        output win_col,
        output frame_done
    );
endinterface

// File: rtl/conv_window_buffer.sv
// Raster-to-window front end for the Sobel path. Two line buffers
// reconstruct the column above each incoming pixel. A 3x3 shift window is
// issued for every full neighbourhood, and the input is stalled until the
// convolution stage returns calc_done.
module conv_window_buffer #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_buffer_if.slave  bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Line buffers: lb0 holds row r-1 and lb1 holds row r-2, one entry per column.
    logic [3:0] lb0 [IMG_W];
    logic [3:0] lb1 [IMG_W];

    logic [2:0][2:0][3:0] win;
    logic [CNT_W-1:0]     row;
    logic [CNT_W-1:0]     col;
    logic [CNT_W-1:0]     win_row_q;
    logic [CNT_W-1:0]     win_col_q;
    logic                 last_win;

    logic [AW-1:0]        col_idx;
    logic                 accept;
    logic                 at_col_last;
    logic                 at_row_last;
    logic                 win_valid;

    logic                 pixel_ready_c;
    logic                 calc_enable_c;
    logic                 frame_done_c;

    assign col_idx     = col[AW-1:0];
    assign accept      = bus.pixel_valid & pixel_ready_c;
    assign at_col_last = (col == COL_LAST);
    assign at_row_last = (row == ROW_LAST);
    // Only neighbourhoods that lie fully inside one row pair are windows.
    // This also suppresses the two columns that straddle a row wrap.
    assign win_valid   = (row >= TWO) && (col >= TWO);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept until a window completes, issue once, then wait for calc_done.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_ACCEPT: begin
                if (accept && win_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.calc_done) begin
                    state_next = ST_ACCEPT;
                end
            end
            default: begin
                state_next = ST_ACCEPT;
            end
        endcase
    end

    // Output decode. pixel_ready depends on state only, never on pixel_valid.
    always_comb begin
        pixel_ready_c = 1'b0;
        calc_enable_c = 1'b0;
        frame_done_c  = 1'b0;
        unique case (state)
            ST_ACCEPT: pixel_ready_c = 1'b1;
            ST_ISSUE:  calc_enable_c = 1'b1;
            ST_WAIT:   frame_done_c  = bus.calc_done & last_win & ~rst;
            default:   pixel_ready_c = 1'b0;
        endcase
    end

    // Line buffer update on each accepted pixel. The buffers are not reset,
    // because the first two rows of a frame never issue a window.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= bus.pixel_in;
        end
    end

    // Window shift, raster counters and capture of the window centre coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= '0;
            row       <= '0;
            col       <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            last_win  <= 1'b0;
        end else if (accept) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col_idx];
            win[1][2] <= lb0[col_idx];
            win[2][2] <= bus.pixel_in;

            if (at_col_last) begin
                col <= '0;
                row <= at_row_last ? '0 : row + ONE;
            end else begin
                col <= col + ONE;
            end

            if (win_valid) begin
                win_row_q <= row - ONE;
                win_col_q <= col - ONE;
                last_win  <= at_col_last & at_row_last;
            end
        end
    end

    assign bus.pixel_ready = pixel_ready_c;
    assign bus.calc_enable = calc_enable_c;
    assign bus.frame_done  = frame_done_c;
    assign bus.pixels      = win;
    assign bus.win_row     = win_row_q;
    assign bus.win_col     = win_col_q;
endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer. It uses a 4x4 instance for the
// handshake scenarios and an 8x8 instance for the bubble stream.
module tb_conv_window_buffer;
    logic clk;
    logic rst;

    conv_window_buffer_if #(.CNT_W(8)) bus4 ();
    conv_window_buffer_if #(.CNT_W(8)) bus8 ();

    conv_window_buffer #(.IMG_W(4), .IMG_H(4), .CNT_W(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    conv_window_buffer #(.IMG_W(8), .IMG_H(8), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Hand-computed 4x4 windows for pixel k = k mod 16. [0][0] is in the low nibble.
    logic [35:0] exp4 [4] = '{36'hA98654210, 36'hBA9765321, 36'hEDCA98654, 36'hFEDBA9765};
    int          exp_r [4] = '{1, 1, 2, 2};
    int          exp_c [4] = '{1, 2, 1, 2};

    logic [35:0] cap_pix [$];
    int          cap_row [$];
    int          cap_col [$];
    int          fd_at   [$];
    int          fd_cnt;

    function automatic logic [3:0] pix8(input int k);
        return 4'((k * 5 + 3) % 16);
    endfunction

    task automatic clear_caps();
        cap_pix.delete();
        cap_row.delete();
        cap_col.delete();
        fd_at.delete();
        fd_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus4.pixel_valid = 1'b0;
        bus4.calc_done   = 1'b0;
        bus8.pixel_valid = 1'b0;
        bus8.calc_done   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams 4x4 pixels start..npix-1 and answers each window after 'delay' cycles.
    task automatic stream4(input int start, input int npix, input int delay, output bit timeout);
        int sent;
        int cd;
        int cyc;
        bit wa;
        sent = start;
        cd = -1;
        cyc = 0;
        timeout = 1'b0;
        forever begin
            @(negedge clk);
            bus4.calc_done = 1'b0;
            if (bus4.calc_enable) begin
                cap_pix.push_back(bus4.pixels);
                cap_row.push_back(int'(bus4.win_row));
                cap_col.push_back(int'(bus4.win_col));
                cd = delay;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                bus4.calc_done = 1'b1;
                cd = -1;
            end
            bus4.pixel_valid = (sent < npix);
            bus4.pixel_in = 4'(sent % 16);
            #1;
            if (bus4.frame_done) begin
                fd_cnt++;
                fd_at.push_back(cap_pix.size());
            end
            wa = bus4.pixel_valid && bus4.pixel_ready;
            if (sent >= npix && cd < 0 && !bus4.calc_done && bus4.pixel_ready) break;
            cyc++;
            if (cyc > 2000) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            if (wa) sent++;
        end
        bus4.pixel_valid = 1'b0;
        bus4.calc_done = 1'b0;
    endtask

    // Feeds pixels from 'start' until a window is issued. Returns at the negedge of the ISSUE cycle.
    task automatic feed_until_enable(input int start, output int sent, output bit timeout);
        bit wa;
        sent = start;
        timeout = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (bus4.calc_enable) break;
            if (cyc > 200) begin
                timeout = 1'b1;
                break;
            end
            bus4.pixel_valid = 1'b1;
            bus4.pixel_in = 4'(sent % 16);
            wa = bus4.pixel_ready;
            @(posedge clk);
            if (wa) sent++;
        end
        bus4.pixel_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus4.pixel_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus4.pixel_ready); end
        total++; if (bus4.calc_enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b want=0", bus4.calc_enable); end
        total++; if (bus4.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus4.frame_done); end
        total++; if (bus4.pixels !== 36'h0) begin bad++; $display("FAIL reset_pixels got=%h want=0", bus4.pixels); end
        total++; if ({bus4.win_row, bus4.win_col} !== 16'h0) begin bad++; $display("FAIL reset_coord got=%0d,%0d want=0,0", bus4.win_row, bus4.win_col); end
        total++; if ({dut4.row, dut4.col} !== 16'h0) begin bad++; $display("FAIL reset_counters got=%0d,%0d want=0,0", dut4.row, dut4.col); end
        total++; if (bus8.pixel_ready !== 1'b1) begin bad++; $display("FAIL reset_ready8 got=%b want=1", bus8.pixel_ready); end
    endtask

    task automatic test_basic();
        bit to;
        do_reset();
        clear_caps();
        stream4(0, 16, 2, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=timeout want=complete"); end
        total++; if (cap_pix.size() != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", cap_pix.size()); end
        for (int i = 0; i < 4 && i < cap_pix.size(); i++) begin
            total++; if (cap_pix[i] !== exp4[i]) begin bad++; $display("FAIL basic_win%0d got=%h want=%h", i, cap_pix[i], exp4[i]); end
            total++; if (cap_row[i] != exp_r[i] || cap_col[i] != exp_c[i]) begin
                bad++; $display("FAIL basic_coord%0d got=%0d,%0d want=%0d,%0d", i, cap_row[i], cap_col[i], exp_r[i], exp_c[i]);
            end
        end
        total++; if (fd_cnt != 1) begin bad++; $display("FAIL basic_fd_count got=%0d want=1", fd_cnt); end
        if (fd_at.size() > 0) begin
            total++; if (fd_at[0] != 4) begin bad++; $display("FAIL basic_fd_window got=%0d want=4", fd_at[0]); end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        bit to;
        do_reset();
        clear_caps();
        feed_until_enable(0, sent, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=timeout want=enable"); end
        total++; if (bus4.pixels !== exp4[0]) begin bad++; $display("FAIL bp_first got=%h want=%h", bus4.pixels, exp4[0]); end
        bus4.pixel_valid = 1'b1;
        bus4.pixel_in = 4'(sent % 16);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++; if (bus4.pixel_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got=%b want=0", i, bus4.pixel_ready); end
            total++; if (bus4.pixels !== exp4[0]) begin bad++; $display("FAIL bp_stable c%0d got=%h want=%h", i, bus4.pixels, exp4[0]); end
        end
        bus4.calc_done = 1'b1;
        bus4.pixel_valid = 1'b0;
        @(negedge clk);
        bus4.calc_done = 1'b0;
        total++; if (bus4.pixel_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", bus4.pixel_ready); end
        total++; if ({dut4.row, dut4.col} !== {8'd2, 8'd3}) begin bad++; $display("FAIL bp_pos got=%0d,%0d want=2,3", dut4.row, dut4.col); end
        stream4(sent, 16, 2, to);
        total++; if (to) begin bad++; $display("FAIL bp_stream_timeout got=timeout want=complete"); end
        total++; if (cap_pix.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", cap_pix.size()); end
        for (int i = 0; i < 3 && i < cap_pix.size(); i++) begin
            total++; if (cap_pix[i] !== exp4[i+1]) begin bad++; $display("FAIL bp_win%0d got=%h want=%h", i + 1, cap_pix[i], exp4[i+1]); end
        end
    endtask

    task automatic test_stray_done();
        int sent;
        bit to;
        do_reset();
        bus4.calc_done = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus4.pixel_ready !== 1'b1 || bus4.calc_enable !== 1'b0) begin
            bad++; $display("FAIL stray_accept got=rdy%b en%b want=rdy1 en0", bus4.pixel_ready, bus4.calc_enable);
        end
        total++; if (bus4.pixels !== 36'h0 || dut4.col !== 8'd0) begin bad++; $display("FAIL stray_idle got=%h col%0d want=0 col0", bus4.pixels, dut4.col); end
        feed_until_enable(0, sent, to);
        total++; if (to || bus4.pixels !== exp4[0]) begin bad++; $display("FAIL stray_window got=%h to=%0d want=%h", bus4.pixels, to, exp4[0]); end
        @(negedge clk);
        bus4.calc_done = 1'b0;
        total++; if (bus4.pixel_ready !== 1'b0) begin bad++; $display("FAIL stray_issue_ignored got=%b want=0", bus4.pixel_ready); end
        repeat (3) @(negedge clk);
        total++; if (bus4.pixel_ready !== 1'b0 || bus4.calc_enable !== 1'b0) begin
            bad++; $display("FAIL stray_wait_hold got=rdy%b en%b want=rdy0 en0", bus4.pixel_ready, bus4.calc_enable);
        end
        bus4.calc_done = 1'b1;
        @(negedge clk);
        bus4.calc_done = 1'b0;
        total++; if (bus4.pixel_ready !== 1'b1) begin bad++; $display("FAIL stray_return got=%b want=1", bus4.pixel_ready); end
        total++; if (bus4.win_row !== 8'd1 || bus4.win_col !== 8'd1) begin bad++; $display("FAIL stray_coord got=%0d,%0d want=1,1", bus4.win_row, bus4.win_col); end
    endtask

    task automatic test_midreset();
        int sent;
        int sent2;
        bit to;
        do_reset();
        clear_caps();
        feed_until_enable(0, sent, to);
        @(negedge clk);
        bus4.calc_done = 1'b1;
        @(negedge clk);
        bus4.calc_done = 1'b0;
        feed_until_enable(sent, sent2, to);
        total++; if (to || bus4.win_row !== 8'd1 || bus4.win_col !== 8'd2) begin
            bad++; $display("FAIL mid_win12 got=%0d,%0d to=%0d want=1,2", bus4.win_row, bus4.win_col, to);
        end
        @(negedge clk);
        rst = 1'b1;
        bus4.calc_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus4.calc_done = 1'b0;
        total++; if (bus4.pixel_ready !== 1'b1 || bus4.calc_enable !== 1'b0) begin
            bad++; $display("FAIL mid_state got=rdy%b en%b want=rdy1 en0", bus4.pixel_ready, bus4.calc_enable);
        end
        total++; if (bus4.pixels !== 36'h0) begin bad++; $display("FAIL mid_pixels got=%h want=0", bus4.pixels); end
        total++; if ({dut4.row, dut4.col, bus4.win_row, bus4.win_col} !== 32'h0) begin
            bad++; $display("FAIL mid_counters got=%0d,%0d,%0d,%0d want=0,0,0,0", dut4.row, dut4.col, bus4.win_row, bus4.win_col);
        end
        stream4(0, 16, 2, to);
        total++; if (to || cap_pix.size() != 4) begin bad++; $display("FAIL mid_count got=%0d to=%0d want=4", cap_pix.size(), to); end
        if (cap_pix.size() > 0) begin
            total++; if (cap_pix[0] !== exp4[0] || cap_row[0] != 1 || cap_col[0] != 1) begin
                bad++; $display("FAIL mid_first got=%h (%0d,%0d) want=%h (1,1)", cap_pix[0], cap_row[0], cap_col[0], exp4[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        do_reset();
        clear_caps();
        stream4(0, 32, 2, to);
        total++; if (to) begin bad++; $display("FAIL b2b_timeout got=timeout want=complete"); end
        total++; if (cap_pix.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", cap_pix.size()); end
        total++; if (fd_cnt != 2) begin bad++; $display("FAIL b2b_fd got=%0d want=2", fd_cnt); end
        for (int i = 0; i < 8 && i < cap_pix.size(); i++) begin
            total++; if (cap_pix[i] !== exp4[i % 4]) begin bad++; $display("FAIL b2b_win%0d got=%h want=%h", i, cap_pix[i], exp4[i % 4]); end
        end
    endtask

    task automatic test_bubbles();
        logic [7:0]  lfsr;
        logic [35:0] expw;
        int sent;
        int cd;
        int nwin;
        int nfd;
        int wr;
        int wc;
        bit wa;
        bit to;
        do_reset();
        lfsr = 8'hA5;
        sent = 0;
        cd = -1;
        nwin = 0;
        nfd = 0;
        to = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            bus8.calc_done = 1'b0;
            if (bus8.calc_enable) begin
                wr = 1 + nwin / 6;
                wc = 1 + nwin % 6;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        expw[(r*3+c)*4 +: 4] = pix8((wr - 1 + r) * 8 + (wc - 1 + c));
                total++; if (bus8.pixels !== expw || int'(bus8.win_row) != wr || int'(bus8.win_col) != wc) begin
                    bad++; $display("FAIL bub_win%0d got=%h (%0d,%0d) want=%h (%0d,%0d)", nwin, bus8.pixels, bus8.win_row, bus8.win_col, expw, wr, wc);
                end
                nwin++;
                cd = 1 + nwin % 3;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                bus8.calc_done = 1'b1;
                cd = -1;
            end
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus8.pixel_valid = (sent < 64) && lfsr[0];
            bus8.pixel_in = pix8(sent);
            #1;
            if (bus8.frame_done) nfd++;
            wa = bus8.pixel_valid && bus8.pixel_ready;
            if (sent >= 64 && cd < 0 && !bus8.calc_done && bus8.pixel_ready) break;
            if (cyc > 5000) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            if (wa) sent++;
        end
        bus8.pixel_valid = 1'b0;
        bus8.calc_done = 1'b0;
        total++; if (to) begin bad++; $display("FAIL bub_timeout got=timeout want=complete"); end
        total++; if (nwin != 36) begin bad++; $display("FAIL bub_count got=%0d want=36", nwin); end
        total++; if (nfd != 1) begin bad++; $display("FAIL bub_fd got=%0d want=1", nfd); end
    endtask

    initial begin
        rst = 1'b1;
        bus4.pixel_in = 4'h0;
        bus4.pixel_valid = 1'b0;
        bus4.calc_done = 1'b0;
        bus8.pixel_in = 4'h0;
        bus8.pixel_valid = 1'b0;
        bus8.calc_done = 1'b0;
        fd_cnt = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stray_done();
        test_midreset();
        test_back_to_back();
        test_bubbles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
